rpn_sequencer: RTL and testbench

Initiator-side driver for the stack-based ALU. A host loads a short postfix program of tokens (opcode + operand), then pulses `start`. The block issues the tokens to the ALU one at a time and checks the ALU's `overflow` after each one. It captures the value of the last pop and reports completion or the first failing token. It sits between the host/control logic and the ALU's `opcode`/`input_data`/`output_data`/`overflow` pins.

---
 rtl/rpn_pkg.sv | 38 +++
 rtl/rpn_prog_mem.sv | 46 ++++
 rtl/rpn_sequencer.sv | 202 ++++++++++++++++++++
 tb/tb_rpn_sequencer.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rpn_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : rpn_pkg                                                         |
// | Purpose  : Shared definitions for the RPN sequencer: ALU opcode encodings, |
// |            the program token record and the sequencer state encoding.      |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package rpn_pkg;

  // ALU opcode encodings. Any opcode with bit2 clear terminates a program.
  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_END  = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b100;
  localparam logic [2:0] OP_MUL  = 3'b101;
  localparam logic [2:0] OP_PUSH = 3'b110;
  localparam logic [2:0] OP_POP  = 3'b111;

  // Operand width of the token record as seen by host-side software.
  localparam int RPN_TOKEN_DW = 8;

  typedef struct packed {
    logic [2:0]              opcode;
    logic [RPN_TOKEN_DW-1:0] operand;
  } rpn_token_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_CHECK  = 2'd2,
    ST_FINISH = 2'd3
  } rpn_state_t;

  function automatic logic is_end(input logic [2:0] op);
    return ~op[2];
  endfunction

endpackage : rpn_pkg
`default_nettype wire

// File: rtl/rpn_prog_mem.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : rpn_prog_mem                                                    |
// | Purpose  : Token store, synchronous write / asynchronous read. Contents    |
// |            are not reset.                                                  |
// | Ports    : clk        - clock                                              |
// |            i_we       - write strobe                                       |
// |            i_waddr    - write slot                                         |
// |            i_wopcode  - opcode to store                                    |
// |            i_woperand - operand to store                                   |
// |            i_raddr    - read slot                                          |
// |            o_ropcode  - opcode at read slot                                |
// |            o_roperand - operand at read slot                               |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module rpn_prog_mem
  import rpn_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int PROG_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          i_we,
  input  logic [$clog2(PROG_DEPTH)-1:0] i_waddr,
  input  logic [2:0]                    i_wopcode,
  input  logic [DATA_WIDTH-1:0]         i_woperand,
  input  logic [$clog2(PROG_DEPTH)-1:0] i_raddr,
  output logic [2:0]                    o_ropcode,
  output logic [DATA_WIDTH-1:0]         o_roperand
);

  logic [2:0]            r_op_mem   [PROG_DEPTH];
  logic [DATA_WIDTH-1:0] r_opnd_mem [PROG_DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_op_mem[i_waddr]   <= i_wopcode;
      r_opnd_mem[i_waddr] <= i_woperand;
    end
  end

  assign o_ropcode  = r_op_mem[i_raddr];
  assign o_roperand = r_opnd_mem[i_raddr];

endmodule : rpn_prog_mem
`default_nettype wire

// File: rtl/rpn_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : rpn_sequencer                                                   |
// | Purpose  : Issues a stored postfix program to the stack ALU one token at a |
// |            time, checks ALU overflow after each token, captures the last   |
// |            pop value and reports completion or the first faulting slot.    |
// | Ports    : clk, rst (async, active-high)                                   |
// |            prog_we/prog_addr/prog_opcode/prog_operand - program load       |
// |            start - run request; busy/done/error/err_pc/result - status     |
// |            alu_opcode/alu_data - registered ALU drive                      |
// |            alu_output_data/alu_overflow - ALU response                     |
// | Options  : RPN_SEQ_DEPTH_CHECK_EN - pre-issue stack depth checking         |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module rpn_sequencer
  import rpn_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int PROG_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          prog_we,
  input  logic [$clog2(PROG_DEPTH)-1:0] prog_addr,
  input  logic [2:0]                    prog_opcode,
  input  logic [DATA_WIDTH-1:0]         prog_operand,
  input  logic                          start,
  output logic                          busy,
  output logic                          done,
  output logic                          error,
  output logic [$clog2(PROG_DEPTH)-1:0] err_pc,
  output logic [DATA_WIDTH-1:0]         result,
  output logic [2:0]                    alu_opcode,
  output logic [DATA_WIDTH-1:0]         alu_data,
  input  logic [DATA_WIDTH-1:0]         alu_output_data,
  input  logic                          alu_overflow
);

  localparam int               c_AW      = $clog2(PROG_DEPTH);
  localparam logic [c_AW-1:0]  c_LAST_PC = c_AW'(PROG_DEPTH - 1);

  rpn_state_t             r_state;
  logic [c_AW-1:0]        r_pc;
  logic [2:0]             r_cur_op;
  logic                   r_busy;
  logic                   r_done;
  logic                   r_error;
  logic [c_AW-1:0]        r_err_pc;
  logic [DATA_WIDTH-1:0]  r_result;
  logic [2:0]             r_alu_opcode;
  logic [DATA_WIDTH-1:0]  r_alu_data;

  logic                   w_prog_we;
  logic [c_AW-1:0]        w_fetch_pc;
  logic [2:0]             w_mem_op;
  logic [DATA_WIDTH-1:0]  w_mem_operand;
  logic                   w_bypass;
  logic [2:0]             w_fetch_op;
  logic [DATA_WIDTH-1:0]  w_fetch_operand;
  logic                   w_fetch_end;
  logic                   w_depth_fault;
  logic                   w_do_fetch;
  rpn_state_t             w_fetch_target;
  rpn_state_t             w_next_state;

  assign w_prog_we = prog_we && (r_state == ST_IDLE);

  // Slot to fetch on the next edge: slot 0 when starting, pc+1 after a CHECK.
  assign w_fetch_pc = (r_state == ST_IDLE) ? '0 : r_pc + 1'b1;

  rpn_prog_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .PROG_DEPTH (PROG_DEPTH)
  ) u_prog_mem (
    .clk        (clk),
    .i_we       (w_prog_we),
    .i_waddr    (prog_addr),
    .i_wopcode  (prog_opcode),
    .i_woperand (prog_operand),
    .i_raddr    (w_fetch_pc),
    .o_ropcode  (w_mem_op),
    .o_roperand (w_mem_operand)
  );

  // A write landing in the same cycle as start must be seen by the first fetch.
  assign w_bypass        = w_prog_we && (prog_addr == w_fetch_pc);
  assign w_fetch_op      = w_bypass ? prog_opcode  : w_mem_op;
  assign w_fetch_operand = w_bypass ? prog_operand : w_mem_operand;
  assign w_fetch_end     = is_end(w_fetch_op);

  assign w_do_fetch = ((r_state == ST_IDLE) && start) ||
                      ((r_state == ST_CHECK) && !alu_overflow && (r_pc != c_LAST_PC));

`ifdef RPN_SEQ_DEPTH_CHECK_EN
  logic [6:0] r_depth;
  logic [6:0] w_depth_base;
  logic [6:0] w_depth_next;

  // A fresh run always counts from an empty stack.
  assign w_depth_base = (r_state == ST_IDLE) ? 7'd0 : r_depth;
  assign w_depth_next = (w_fetch_op == OP_PUSH) ? w_depth_base + 7'd1 : w_depth_base - 7'd1;

  always_comb begin
    w_depth_fault = 1'b0;
    case (w_fetch_op)
      OP_ADD, OP_MUL: w_depth_fault = (w_depth_base < 7'd2);
      OP_POP:         w_depth_fault = (w_depth_base == 7'd0);
      OP_PUSH:        w_depth_fault = (w_depth_base == 7'd64);
      default:        w_depth_fault = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_depth <= 7'd0;
    end else if (w_do_fetch && !w_fetch_end && !w_depth_fault) begin
      r_depth <= w_depth_next;
    end else if ((r_state == ST_IDLE) && start) begin
      r_depth <= 7'd0;
    end
  end
`else
  assign w_depth_fault = 1'b0;
`endif

  assign w_fetch_target = (w_fetch_end || w_depth_fault) ? ST_FINISH : ST_ISSUE;

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:   if (start) w_next_state = w_fetch_target;
      ST_ISSUE:  w_next_state = ST_CHECK;
      ST_CHECK: begin
        if (alu_overflow || (r_pc == c_LAST_PC)) w_next_state = ST_FINISH;
        else                                     w_next_state = w_fetch_target;
      end
      ST_FINISH: w_next_state = ST_IDLE;
      default:   w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_pc         <= '0;
      r_cur_op     <= OP_NOP;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
      r_err_pc     <= '0;
      r_result     <= '0;
      r_alu_opcode <= OP_NOP;
      r_alu_data   <= '0;
    end else begin
      r_state <= w_next_state;
      r_busy  <= (w_next_state != ST_IDLE);
      r_done  <= (w_next_state == ST_FINISH);

      // The ALU sees a token only during ISSUE; every other cycle is a NOP.
      r_alu_opcode <= OP_NOP;
      r_alu_data   <= '0;

      if ((r_state == ST_IDLE) && start) begin
        r_pc     <= '0;
        r_error  <= 1'b0;
        r_err_pc <= '0;
        r_result <= '0;
      end

      if (r_state == ST_CHECK) begin
        if (alu_overflow) begin
          r_error  <= 1'b1;
          r_err_pc <= r_pc;
        end else begin
          if (r_cur_op == OP_POP) r_result <= alu_output_data;
          if (r_pc != c_LAST_PC)  r_pc     <= r_pc + 1'b1;
        end
      end

      if (w_do_fetch && !w_fetch_end) begin
        if (w_depth_fault) begin
          r_error  <= 1'b1;
          r_err_pc <= w_fetch_pc;
        end else begin
          r_alu_opcode <= w_fetch_op;
          r_alu_data   <= w_fetch_operand;
          r_cur_op     <= w_fetch_op;
        end
      end
    end
  end

  assign busy       = r_busy;
  assign done       = r_done;
  assign error      = r_error;
  assign err_pc     = r_err_pc;
  assign result     = r_result;
  assign alu_opcode = r_alu_opcode;
  assign alu_data   = r_alu_data;

endmodule : rpn_sequencer
`default_nettype wire

// File: tb/tb_rpn_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_rpn_sequencer                                                |
// | Purpose  : Self-checking bench for rpn_sequencer with a behavioural stack  |
// |            ALU and a reference interpreter feeding a scoreboard.           |
// | Options  : RPN_SEQ_DEPTH_CHECK_EN - expectations follow the DUT build      |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_rpn_sequencer;
  import rpn_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       prog_we;
  logic [3:0] prog_addr;
  logic [2:0] prog_opcode;
  logic [7:0] prog_operand;
  logic       start;
  logic       busy, done, error;
  logic [3:0] err_pc;
  logic [7:0] result;
  logic [2:0] alu_opcode;
  logic [7:0] alu_data;
  logic [7:0] alu_output_data;
  logic       alu_overflow;

  rpn_sequencer #(.DATA_WIDTH(8), .PROG_DEPTH(16)) dut (
    .clk(clk), .rst(rst), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_opcode(prog_opcode), .prog_operand(prog_operand), .start(start),
    .busy(busy), .done(done), .error(error), .err_pc(err_pc), .result(result),
    .alu_opcode(alu_opcode), .alu_data(alu_data),
    .alu_output_data(alu_output_data), .alu_overflow(alu_overflow)
  );

  always #5 clk = ~clk;

  // Behavioural stack ALU: 64 entries, overflow on stack under/overrun.
  logic [7:0] alu_stk [64];
  int         alu_sp = 0;
  logic       tb_alu_clr = 1'b0;
  initial begin
    alu_output_data = 8'h00;
    alu_overflow    = 1'b0;
  end
  always @(posedge clk) begin
    alu_overflow <= 1'b0;
    if (tb_alu_clr) alu_sp <= 0;
    else begin
      case (alu_opcode)
        3'b110: if (alu_sp == 64) alu_overflow <= 1'b1;
                else begin alu_stk[alu_sp] <= alu_data; alu_sp <= alu_sp + 1; end
        3'b100, 3'b101:
                if (alu_sp < 2) alu_overflow <= 1'b1;
                else begin
                  alu_stk[alu_sp-2] <= (alu_opcode == 3'b100) ? alu_stk[alu_sp-1] + alu_stk[alu_sp-2]
                                                              : alu_stk[alu_sp-1] * alu_stk[alu_sp-2];
                  alu_sp <= alu_sp - 1;
                end
        3'b111: if (alu_sp == 0) alu_overflow <= 1'b1;
                else begin alu_output_data <= alu_stk[alu_sp-1]; alu_sp <= alu_sp - 1; end
        default: ;
      endcase
    end
  end

  // Count ALU-visible tokens (non-NOP opcode cycles).
  int tb_issued = 0;
  always @(negedge clk) if (alu_opcode != 3'b000) tb_issued <= tb_issued + 1;

  typedef struct {
    int         lat;
    int         issued;
    logic [7:0] result;
    logic       error;
    logic [3:0] err_pc;
  } exp_t;

  exp_t       sb[$];
  rpn_token_t img [16];
  int         n_vec = 0;
  int         n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Reference interpreter over the bench's program image, ALU stack empty at start.
  task automatic model_run(output exp_t e);
    logic [7:0] st [64];
    int sp = 0, seq_d = 0, n = 0;
    bit stop = 0;
    logic [2:0] op;
    e.result = 8'h00; e.error = 1'b0; e.err_pc = 4'h0;
    for (int pc = 0; pc < 16 && !stop; pc++) begin
      op = img[pc].opcode;
      if (!op[2]) begin
        stop = 1;
      end else begin
`ifdef RPN_SEQ_DEPTH_CHECK_EN
        if (((op == OP_ADD || op == OP_MUL) && seq_d < 2) || (op == OP_POP && seq_d == 0) ||
            (op == OP_PUSH && seq_d == 64)) begin
          e.error = 1'b1; e.err_pc = 4'(pc); stop = 1;
        end else seq_d = (op == OP_PUSH) ? seq_d + 1 : seq_d - 1;
`endif
        if (!stop) begin
          n++;
          case (op)
            OP_PUSH: if (sp == 64) stop = 1; else begin st[sp] = img[pc].operand; sp++; end
            OP_POP:  if (sp == 0) stop = 1; else begin sp--; e.result = st[sp]; end
            default: if (sp < 2) stop = 1;
                     else begin
                       st[sp-2] = (op == OP_ADD) ? st[sp-1] + st[sp-2] : st[sp-1] * st[sp-2];
                       sp--;
                     end
          endcase
          if (stop) begin e.error = 1'b1; e.err_pc = 4'(pc); end
        end
      end
    end
    e.lat = 2 * n + 1;
    e.issued = n;
  endtask

  task automatic clear_img();
    for (int i = 0; i < 16; i++) img[i] = '{opcode: OP_END, operand: 8'h00};
  endtask

  task automatic set_tok(input int i, input logic [2:0] op, input logic [7:0] d);
    img[i] = '{opcode: op, operand: d};
  endtask

  task automatic write_all();
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      prog_we = 1'b1; prog_addr = 4'(i);
      prog_opcode = img[i].opcode; prog_operand = img[i].operand;
    end
    @(negedge clk);
    prog_we = 1'b0;
  endtask

  task automatic alu_flush();
    @(negedge clk); tb_alu_clr = 1'b1;
    @(negedge clk); tb_alu_clr = 1'b0;
  endtask

  // Start a run, optionally writing slot 0 together with start, optionally
  // poking start+write while busy at a given latency; then score completion.
  task automatic run_check(input string name, input bit wr_at_start, input int poke_at,
                           input logic [2:0] wop, input logic [7:0] wdat);
    exp_t e;
    int   lat, base;
    bit   found = 0;
    model_run(e);
    sb.push_back(e);
    alu_flush();
    @(negedge clk);
    start = 1'b1;
    if (wr_at_start) begin
      prog_we = 1'b1; prog_addr = 4'h0; prog_opcode = wop; prog_operand = wdat;
    end
    base = tb_issued;
    @(posedge clk); #1;
    start = 1'b0; prog_we = 1'b0;
    lat = 1;
    while (lat <= 100 && !found) begin
      if (done) found = 1;
      else begin
        if (lat == poke_at) begin
          start = 1'b1; prog_we = 1'b1; prog_addr = 4'h0; prog_opcode = wop; prog_operand = wdat;
        end else begin
          start = 1'b0; prog_we = 1'b0;
        end
        @(posedge clk); #1;
        lat++;
      end
    end
    start = 1'b0; prog_we = 1'b0;
    if (!found) begin
      chk({name, " done timeout"}, 32'd0, 32'd1);
      void'(sb.pop_front());
    end else begin
      e = sb.pop_front();
      chk({name, " latency"}, 32'(lat), 32'(e.lat));
      chk({name, " result"}, {24'd0, result}, {24'd0, e.result});
      chk({name, " error"}, {31'd0, error}, {31'd0, e.error});
      chk({name, " err_pc"}, {28'd0, err_pc}, {28'd0, e.err_pc});
      @(negedge clk);
      chk({name, " issued"}, 32'(tb_issued - base), 32'(e.issued));
      @(posedge clk); #1;
      chk({name, " done pulse"}, {31'd0, done}, 32'd0);
      chk({name, " busy idle"}, {31'd0, busy}, 32'd0);
    end
  endtask

  task automatic chk_reset_vals(input string name);
    chk({name, " busy"}, {31'd0, busy}, 32'd0);
    chk({name, " done"}, {31'd0, done}, 32'd0);
    chk({name, " error"}, {31'd0, error}, 32'd0);
    chk({name, " err_pc"}, {28'd0, err_pc}, 32'd0);
    chk({name, " result"}, {24'd0, result}, 32'd0);
    chk({name, " alu_op"}, {29'd0, alu_opcode}, 32'd0);
    chk({name, " alu_data"}, {24'd0, alu_data}, 32'd0);
  endtask

  task automatic load_p1();
    clear_img();
    set_tok(0, OP_PUSH, 8'd3); set_tok(1, OP_PUSH, 8'd4); set_tok(2, OP_ADD, 8'd0);
    set_tok(3, OP_PUSH, 8'd2); set_tok(4, OP_MUL, 8'd0); set_tok(5, OP_POP, 8'd0);
    write_all();
  endtask

  initial begin
    int dcnt;
    rst = 1'b1; start = 1'b0; prog_we = 1'b0;
    prog_addr = 4'h0; prog_opcode = 3'b000; prog_operand = 8'h00;
    repeat (3) @(posedge clk);
    #1 chk_reset_vals("reset");
    @(negedge clk) rst = 1'b0;

    // Arithmetic program: (3+4)*2 = 14.
    load_p1();
    run_check("p1", 1'b0, 0, 3'b000, 8'h00);

    // Underflowing add: ALU fault, or pre-issue depth fault when enabled.
    clear_img();
    set_tok(0, OP_PUSH, 8'd5); set_tok(1, OP_ADD, 8'd0);
    write_all();
    run_check("p2", 1'b0, 0, 3'b000, 8'h00);

    // Full program, no END: runs through slot 15 and stops.
    clear_img();
    for (int k = 0; k < 8; k++) begin
      set_tok(2 * k, OP_PUSH, 8'(8'd10 + 8'(k)));
      set_tok(2 * k + 1, OP_POP, 8'd0);
    end
    write_all();
    run_check("p3", 1'b0, 0, 3'b000, 8'h00);

    // END in slot 0 completes in one cycle.
    clear_img();
    write_all();
    run_check("p4", 1'b0, 0, 3'b000, 8'h00);

    // Write slot 0 in the same cycle as start: execution sees the new token.
    clear_img();
    set_tok(1, OP_POP, 8'd0);
    write_all();
    set_tok(0, OP_PUSH, 8'd9);
    run_check("p5", 1'b1, 0, OP_PUSH, 8'd9);

    // Reset during CHECK of slot 2.
    load_p1();
    alu_flush();
    @(negedge clk) start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst = 1'b1;
    #1 chk_reset_vals("midrst");
    @(negedge clk) rst = 1'b0;
    dcnt = 0;
    repeat (10) begin @(posedge clk); #1 if (done) dcnt++; end
    chk("midrst no done", 32'(dcnt), 32'd0);
    run_check("p1 after rst", 1'b0, 0, 3'b000, 8'h00);

    // start + prog_we while busy are ignored; program stays intact.
    run_check("busy poke", 1'b0, 4, OP_END, 8'h00);
    dcnt = 0;
    repeat (10) begin @(posedge clk); #1 if (done) dcnt++; end
    chk("busy poke single done", 32'(dcnt), 32'd0);
    run_check("p1 rerun", 1'b0, 0, 3'b000, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global timeout: got running expected finished");
    $fatal(1);
  end

endmodule : tb_rpn_sequencer
`default_nettype wire
